// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle controller and its datapath.
// The controller side drives every control strobe; the datapath side supplies decode fields and flags.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       OP;
    logic [2:0]       fun3;
    logic             zeroflag;
    logic             ltflag;
    logic             mem_ready;

    logic             pc_wrt;
    logic             adr_src;
    logic             mem_wrt;
    logic             ir_wrt;
    logic             reg_wrt;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       ALUop;
    logic [1:0]       immsrc;
    logic             illegal;
    logic [CNT_W-1:0] instret;

    modport master (
        input  OP, fun3, zeroflag, ltflag, mem_ready,
        output pc_wrt, adr_src, mem_wrt, ir_wrt, reg_wrt,
        output result_src, alu_src_a, alu_src_b, ALUop, immsrc,
        output illegal, instret
    );

    modport slave (
        output OP, fun3, zeroflag, ltflag, mem_ready,
        input  pc_wrt, adr_src, mem_wrt, ir_wrt, reg_wrt,
        input  result_src, alu_src_a, alu_src_b, ALUop, immsrc,
        input  illegal, instret
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback over one memory
// port and one ALU, with memory wait states, optional JAL and BNE/BLT/BGE, an illegal trap and instret.
module multicycle_ctrl #(
    parameter bit SUPPORT_JAL  = 1'b1,
    parameter bit SUPPORT_BCMP = 1'b1,
    parameter bit MEM_WAIT     = 1'b1,
    parameter int CNT_W        = 32
) (
    input logic               clk,
    input logic               rst_n,
    multicycle_ctrl_if.master bus
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    state_e           state;
    state_e           next_state;
    logic [CNT_W-1:0] instret_q;
    logic             illegal_q;

    logic             ready;
    logic             taken;
    logic             retire;
    logic             pc_wrt;
    logic             adr_src;
    logic             mem_wrt;
    logic             ir_wrt;
    logic             reg_wrt;
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       immsrc;

    // Without wait-state support every access is treated as completing in its first cycle.
    assign ready = MEM_WAIT ? bus.mem_ready : 1'b1;

    always_comb begin
        taken = 1'b0;
        case (bus.fun3)
            3'b000:  taken = bus.zeroflag;
            3'b001:  taken = SUPPORT_BCMP && !bus.zeroflag;
            3'b100:  taken = SUPPORT_BCMP && bus.ltflag;
            3'b101:  taken = SUPPORT_BCMP && !bus.ltflag;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.OP)
            OP_SW:   immsrc = 2'b01;
            OP_B:    immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        next_state = S_TRAP;
        pc_wrt     = 1'b0;
        adr_src    = 1'b0;
        mem_wrt    = 1'b0;
        ir_wrt     = 1'b0;
        reg_wrt    = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        retire     = 1'b0;

        case (state)
            S_FETCH: begin
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_wrt     = ready;
                pc_wrt     = ready;
                next_state = ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.OP)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECR;
                    OP_I:         next_state = S_EXECI;
                    OP_B:         next_state = S_BRANCH;
                    OP_JAL:       next_state = SUPPORT_JAL ? S_JAL : S_TRAP;
                    default:      next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                next_state = (bus.OP == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                next_state = ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_wrt    = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src    = 1'b1;
                mem_wrt    = 1'b1;
                retire     = ready;
                next_state = ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = 2'b10;
                alu_src_b  = 2'b01;
                alu_op     = 2'b10;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_wrt    = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = 2'b01;
                pc_wrt     = taken;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_JAL: begin
                // PC takes the target computed in DECODE; the link write happens in ALUWB.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_wrt     = 1'b1;
                next_state = S_ALUWB;
            end
            S_TRAP:  next_state = S_TRAP;
            default: next_state = S_TRAP;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state <= next_state;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            if (next_state == S_TRAP) begin
                illegal_q <= 1'b1;
            end
        end
    end

    assign bus.pc_wrt     = pc_wrt;
    assign bus.adr_src    = adr_src;
    assign bus.mem_wrt    = mem_wrt;
    assign bus.ir_wrt     = ir_wrt;
    assign bus.reg_wrt    = reg_wrt;
    assign bus.result_src = result_src;
    assign bus.alu_src_a  = alu_src_a;
    assign bus.alu_src_b  = alu_src_b;
    assign bus.ALUop      = alu_op;
    assign bus.immsrc     = immsrc;
    assign bus.illegal    = illegal_q;
    assign bus.instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl: three parameterisations share stimulus and are checked
// against an instruction-level timing model derived from the per-class cycle rules.
module tb_multicycle_ctrl;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum int {C_LW, C_SW, C_R, C_I, C_BR, C_JAL, C_ILL} cls_e;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] f3;
    logic       zf;
    logic       lt;
    logic       mr;

    int          checks = 0;
    int          errors = 0;
    int          sel_g  = 0;
    int unsigned exp_cnt [3];

    logic [4:0]  s_en;   // {ir_wrt, pc_wrt, reg_wrt, mem_wrt, adr_src}
    logic [1:0]  s_rs, s_a, s_b, s_op, s_imm;
    logic        s_ill;
    logic [31:0] s_cnt;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(32)) bus0 ();
    multicycle_ctrl_if #(.CNT_W(32)) bus1 ();
    multicycle_ctrl_if #(.CNT_W(4))  bus2 ();

    assign bus0.OP = op;  assign bus0.fun3 = f3;  assign bus0.zeroflag = zf;
    assign bus0.ltflag = lt;  assign bus0.mem_ready = mr;
    assign bus1.OP = op;  assign bus1.fun3 = f3;  assign bus1.zeroflag = zf;
    assign bus1.ltflag = lt;  assign bus1.mem_ready = mr;
    assign bus2.OP = op;  assign bus2.fun3 = f3;  assign bus2.zeroflag = zf;
    assign bus2.ltflag = lt;  assign bus2.mem_ready = mr;

    multicycle_ctrl #(.SUPPORT_JAL(1'b1), .SUPPORT_BCMP(1'b1), .MEM_WAIT(1'b1), .CNT_W(32))
        u_main (.clk(clk), .rst_n(rst_n), .bus(bus0));
    multicycle_ctrl #(.SUPPORT_JAL(1'b0), .SUPPORT_BCMP(1'b0), .MEM_WAIT(1'b0), .CNT_W(32))
        u_nox (.clk(clk), .rst_n(rst_n), .bus(bus1));
    multicycle_ctrl #(.SUPPORT_JAL(1'b1), .SUPPORT_BCMP(1'b1), .MEM_WAIT(1'b1), .CNT_W(4))
        u_w4 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    always_comb begin
        case (sel_g)
            1: begin
                s_en  = {bus1.ir_wrt, bus1.pc_wrt, bus1.reg_wrt, bus1.mem_wrt, bus1.adr_src};
                s_rs  = bus1.result_src; s_a = bus1.alu_src_a; s_b = bus1.alu_src_b;
                s_op  = bus1.ALUop; s_imm = bus1.immsrc; s_ill = bus1.illegal;
                s_cnt = bus1.instret;
            end
            2: begin
                s_en  = {bus2.ir_wrt, bus2.pc_wrt, bus2.reg_wrt, bus2.mem_wrt, bus2.adr_src};
                s_rs  = bus2.result_src; s_a = bus2.alu_src_a; s_b = bus2.alu_src_b;
                s_op  = bus2.ALUop; s_imm = bus2.immsrc; s_ill = bus2.illegal;
                s_cnt = {28'd0, bus2.instret};
            end
            default: begin
                s_en  = {bus0.ir_wrt, bus0.pc_wrt, bus0.reg_wrt, bus0.mem_wrt, bus0.adr_src};
                s_rs  = bus0.result_src; s_a = bus0.alu_src_a; s_b = bus0.alu_src_b;
                s_op  = bus0.ALUop; s_imm = bus0.immsrc; s_ill = bus0.illegal;
                s_cnt = bus0.instret;
            end
        endcase
    end

    function automatic bit jal_ok(input int s);
        return s != 1;
    endfunction

    function automatic bit bcmp_ok(input int s);
        return s != 1;
    endfunction

    function automatic bit mwait(input int s);
        return s != 1;
    endfunction

    function automatic logic [31:0] cnt_mask(input int s);
        return (s == 2) ? 32'h0000_000F : 32'hFFFF_FFFF;
    endfunction

    function automatic cls_e classify(input logic [6:0] o, input bit jok);
        case (o)
            OP_LW:   return C_LW;
            OP_SW:   return C_SW;
            OP_R:    return C_R;
            OP_I:    return C_I;
            OP_B:    return C_BR;
            OP_JAL:  return jok ? C_JAL : C_ILL;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        case (o)
            OP_SW:   return 2'b01;
            OP_B:    return 2'b10;
            OP_JAL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit exp_taken(input logic [2:0] f, input logic z, input logic l, input bit bc);
        case (f)
            3'b000:  return z;
            3'b001:  return bc && !z;
            3'b100:  return bc && l;
            3'b101:  return bc && !l;
            default: return 1'b0;
        endcase
    endfunction

    // FETCH selects: PC as address, PC + 4 through the ALU, ALU result routed to PC.
    function automatic bit is_fetch();
        return s_en[2:0] == 3'b000 && s_a == 2'b00 && s_b == 2'b10 && s_op == 2'b00 && s_rs == 2'b10;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        op = 7'd0; f3 = 3'd0; zf = 1'b0; lt = 1'b0; mr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) exp_cnt[i] = 0;
    endtask

    task automatic run_instr(input int sel, input logic [6:0] op_i, input logic [2:0] f3_i,
                             input logic zf_i, input logic lt_i, input int wf, input int wm);
        cls_e       cls;
        int         ewf, ewm, n, ms;
        bit         mem, tk, wb, pc_exp;
        logic [4:0] exp_en;
        sel_g = sel;
        cls   = classify(op_i, jal_ok(sel));
        ewf   = mwait(sel) ? wf : 0;
        ewm   = mwait(sel) ? wm : 0;
        mem   = (cls == C_LW) || (cls == C_SW);
        ms    = ewf + 3;
        tk    = exp_taken(f3_i, zf_i, lt_i, bcmp_ok(sel));
        wb    = (cls == C_LW) || (cls == C_R) || (cls == C_I) || (cls == C_JAL);
        case (cls)
            C_LW:    n = ewf + 5 + ewm;
            C_SW:    n = ewf + 4 + ewm;
            C_BR:    n = ewf + 3;
            default: n = ewf + 4;
        endcase
        op = op_i; f3 = f3_i; zf = zf_i; lt = lt_i;
        for (int c = 0; c < n; c++) begin
            if (!mwait(sel))                     mr = 1'($urandom_range(0, 1));
            else if (c < ewf)                    mr = 1'b0;
            else if (c == ewf)                   mr = 1'b1;
            else if (mem && c >= ms && c < ms + ewm) mr = 1'b0;
            else if (mem && c == ms + ewm)       mr = 1'b1;
            else                                 mr = 1'($urandom_range(0, 1));
            @(negedge clk);
            pc_exp = (c == ewf) || (c == ewf + 2 && ((cls == C_BR && tk) || cls == C_JAL));
            exp_en = {c == ewf, pc_exp, wb && c == n - 1, cls == C_SW && c >= ms,
                      mem && c >= ms && c <= ms + ewm};
            checks++;
            if (s_en !== exp_en) begin
                errors++;
                $display("FAIL enables sel=%0d op=%b cyc=%0d got=%b exp=%b", sel, op_i, c, s_en, exp_en);
            end
            checks++;
            if (s_imm !== exp_imm(op_i)) begin
                errors++;
                $display("FAIL immsrc op=%b cyc=%0d got=%b exp=%b", op_i, c, s_imm, exp_imm(op_i));
            end
            if (c <= ewf) begin
                checks++;
                if (!is_fetch()) begin
                    errors++;
                    $display("FAIL fetch_sel cyc=%0d got a=%b b=%b op=%b rs=%b exp 00/10/00/10", c, s_a, s_b, s_op, s_rs);
                end
            end
            if (c == ewf + 1) begin
                checks++;
                if ({s_a, s_b, s_op} !== 6'b01_01_00) begin
                    errors++;
                    $display("FAIL decode_sel got=%b exp=010100", {s_a, s_b, s_op});
                end
            end
            if (c == ewf + 2 && (cls == C_BR || cls == C_R || cls == C_I)) begin
                checks++;
                if ({s_a, s_b, s_op} !== {2'b10, (cls == C_I) ? 2'b01 : 2'b00, (cls == C_BR) ? 2'b01 : 2'b10}) begin
                    errors++;
                    $display("FAIL exec_sel op=%b got a=%b b=%b aluop=%b", op_i, s_a, s_b, s_op);
                end
            end
            if (c == n - 1 && cls == C_LW) begin
                checks++;
                if (s_rs !== 2'b01) begin
                    errors++;
                    $display("FAIL lw_result_src got=%b exp=01", s_rs);
                end
            end
            @(posedge clk);
            #1;
        end
        exp_cnt[sel] = exp_cnt[sel] + 1;
        checks++;
        if (!is_fetch() || s_cnt !== (exp_cnt[sel] & cnt_mask(sel))) begin
            errors++;
            $display("FAIL retire sel=%0d op=%b fetch=%0d instret got=%0d exp=%0d",
                     sel, op_i, is_fetch(), s_cnt, exp_cnt[sel] & cnt_mask(sel));
        end
    endtask

    task automatic run_trap(input int sel, input logic [6:0] op_i, input bit async_rst);
        sel_g = sel;
        op = op_i; mr = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (s_ill !== 1'b0) begin
            errors++;
            $display("FAIL illegal_early got=%b exp=0", s_ill);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            mr = 1'($urandom_range(0, 1));
            op = 7'($urandom);
            @(negedge clk);
            checks++;
            if (s_ill !== 1'b1 || s_en !== 5'b0 || s_cnt !== (exp_cnt[sel] & cnt_mask(sel))) begin
                errors++;
                $display("FAIL trap sel=%0d cyc=%0d got ill=%b en=%b cnt=%0d exp ill=1 en=00000 cnt=%0d",
                         sel, i, s_ill, s_en, s_cnt, exp_cnt[sel] & cnt_mask(sel));
            end
            @(posedge clk); #1;
        end
        if (async_rst) begin
            #2;
            rst_n = 1'b0;
            #1;
            checks++;
            if (s_ill !== 1'b0 || !is_fetch() || s_cnt !== 32'd0) begin
                errors++;
                $display("FAIL async_reset got ill=%b fetch=%0d cnt=%0d exp ill=0 fetch=1 cnt=0",
                         s_ill, is_fetch(), s_cnt);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        op = OP_R; f3 = 3'd0; zf = 1'b0; lt = 1'b0; mr = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel_g = s;
            #1;
            checks++;
            if (!is_fetch() || s_en !== 5'b11000 || s_ill !== 1'b0 || s_cnt !== 32'd0) begin
                errors++;
                $display("FAIL reset sel=%0d got en=%b ill=%b cnt=%0d fetch=%0d exp en=11000 ill=0 cnt=0",
                         s, s_en, s_ill, s_cnt, is_fetch());
            end
        end
        do_reset();
    endtask

    task automatic test_lw();
        do_reset();
        run_instr(0, OP_LW, 3'b010, 1'b0, 1'b0, 0, 0);
        run_instr(0, OP_LW, 3'b010, 1'b1, 1'b1, 2, 2);
    endtask

    task automatic test_sw_wait();
        do_reset();
        run_instr(0, OP_SW, 3'b010, 1'b0, 1'b0, 0, 3);
    endtask

    task automatic test_branch();
        do_reset();
        run_instr(0, OP_B, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr(0, OP_B, 3'b001, 1'b1, 1'b0, 0, 0);
        run_instr(0, OP_B, 3'b100, 1'b0, 1'b1, 0, 0);
        run_instr(0, OP_B, 3'b101, 1'b0, 1'b1, 0, 0);
        run_instr(0, OP_B, 3'b110, 1'b1, 1'b1, 0, 0);
        do_reset();
        run_instr(1, OP_B, 3'b100, 1'b0, 1'b1, 0, 0);
        run_instr(1, OP_B, 3'b000, 1'b1, 1'b0, 0, 0);
    endtask

    task automatic test_jal();
        do_reset();
        run_instr(0, OP_JAL, 3'b000, 1'b0, 1'b0, 0, 0);
        do_reset();
        run_trap(1, OP_JAL, 1'b0);
    endtask

    task automatic test_trap_illegal();
        do_reset();
        run_instr(0, OP_I, 3'b000, 1'b0, 1'b0, 1, 0);
        run_trap(0, 7'b1111111, 1'b1);
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) run_instr(2, OP_R, 3'($urandom), 1'b0, 1'b0, 0, 0);
        checks++;
        if (s_cnt !== 32'd1) begin
            errors++;
            $display("FAIL wrap instret got=%0d exp=1", s_cnt);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [6];
        ops[0] = OP_LW; ops[1] = OP_SW; ops[2] = OP_R;
        ops[3] = OP_I;  ops[4] = OP_B;  ops[5] = OP_JAL;
        do_reset();
        for (int i = 0; i < 30; i++)
            run_instr(0, ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        do_reset();
        for (int i = 0; i < 20; i++)
            run_instr(1, ops[$urandom_range(0, 4)], 3'($urandom), 1'($urandom), 1'($urandom),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_branch();
        test_jal();
        test_trap_illegal();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
